// File: rtl/interrupt_request_ctrl.sv
// Requester side of the interrupt handshake: synchronises two external lines, latches
// and arbitrates pending requests (ID1 > ID0). Define INT_EDGE_TRIG_EN for edge mode.
module interrupt_request_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic       Clock,
   input  logic       SysReset,
   input  logic [1:0] ExtIrq,
   input  logic [1:0] IntMask,
   input  logic       IntAck,
   output logic       IRQ_Int,
   output logic       IID_Sync,
   output logic [1:0] Pending,
   output logic       AckErr
);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } stateT;

   stateT            stateReg;
   logic [CNT_W-1:0] holdCntReg;
   logic [1:0]       syncLine;
   logic [1:0]       pendingNext;
   logic [1:0]       eligible;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gLine
         logic [SYNC_STAGES-1:0] chainReg;

         always_ff @(posedge Clock or negedge SysReset) begin
            if (!SysReset) begin
               chainReg <= '0;
            end else begin
               chainReg <= {chainReg[SYNC_STAGES-2:0], ExtIrq[gi]};
            end
         end

         assign syncLine[gi] = chainReg[SYNC_STAGES-1];
      end
   endgenerate

`ifdef INT_EDGE_TRIG_EN
   logic [1:0] syncDlyReg;
   logic [1:0] setVec;
   logic [1:0] clrVec;

   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset) begin
         syncDlyReg <= '0;
      end else begin
         syncDlyReg <= syncLine;
      end
   end

   assign setVec = syncLine & ~syncDlyReg;

   // Only an ack that actually retires the requested ID clears its pending bit.
   always_comb begin
      clrVec = 2'b00;
      if (IntAck && (stateReg == REQ)) begin
         clrVec = {IID_Sync, ~IID_Sync};
      end
   end

   assign pendingNext = (Pending & ~clrVec) | setVec;
`else
   assign pendingNext = syncLine;
`endif

   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset) begin
         Pending <= 2'b00;
      end else begin
         Pending <= pendingNext;
      end
   end

   assign eligible = Pending & ~IntMask;

   always_ff @(posedge Clock or negedge SysReset) begin
      if (!SysReset) begin
         stateReg   <= IDLE;
         holdCntReg <= '0;
         IRQ_Int    <= 1'b0;
         IID_Sync   <= 1'b0;
         AckErr     <= 1'b0;
      end else begin
         AckErr <= IntAck && (stateReg != REQ);
         case (stateReg)
            IDLE: begin
               if (eligible != 2'b00) begin
                  stateReg <= REQ;
                  IRQ_Int  <= 1'b1;
                  IID_Sync <= eligible[1];
               end
            end
            REQ: begin
               if (IntAck) begin
                  stateReg   <= HOLD;
                  IRQ_Int    <= 1'b0;
                  holdCntReg <= CNT_W'(HOLD_CYCLES - 1);
               end else if (!eligible[IID_Sync]) begin
                  // Requested ID withdrawn or masked: fall back to the other one if possible.
                  if (eligible[~IID_Sync]) begin
                     IID_Sync <= ~IID_Sync;
                  end else begin
                     stateReg <= IDLE;
                     IRQ_Int  <= 1'b0;
                  end
               end else if (!IID_Sync && eligible[1]) begin
                  IID_Sync <= 1'b1;
               end
            end
            HOLD: begin
               IRQ_Int <= 1'b0;
               if (holdCntReg == '0) begin
                  stateReg <= IDLE;
               end else begin
                  holdCntReg <= holdCntReg - 1'b1;
               end
            end
            default: begin
               stateReg <= IDLE;
               IRQ_Int  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Directed bench for interrupt_request_ctrl (SYNC_STAGES=2, HOLD_CYCLES=2); expected
// values follow the build mode selected by INT_EDGE_TRIG_EN.
module tb_interrupt_request_ctrl;
`ifdef INT_EDGE_TRIG_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic       Clock = 1'b0;
   logic       SysReset;
   logic [1:0] ExtIrq;
   logic [1:0] IntMask;
   logic       IntAck;
   logic       IRQ_Int;
   logic       IID_Sync;
   logic [1:0] Pending;
   logic       AckErr;

   int checkCnt = 0;
   int passCnt  = 0;

   interrupt_request_ctrl #(
      .SYNC_STAGES(2),
      .HOLD_CYCLES(2)
   ) dut (
      .Clock   (Clock),
      .SysReset(SysReset),
      .ExtIrq  (ExtIrq),
      .IntMask (IntMask),
      .IntAck  (IntAck),
      .IRQ_Int (IRQ_Int),
      .IID_Sync(IID_Sync),
      .Pending (Pending),
      .AckErr  (AckErr)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checkCnt++;
      if (got === exp) begin
         passCnt++;
         $display("[%0t] %s got=%0h exp=%0h ok", $time, tag, got, exp);
      end else begin
         $display("[%0t] FAIL %s got=%0h exp=%0h", $time, tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 2 time units past the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #2;
      end
   endtask

   task automatic doReset();
      SysReset = 1'b0;
      ExtIrq   = 2'b00;
      IntMask  = 2'b00;
      IntAck   = 1'b0;
      tick(2);
      SysReset = 1'b1;
      tick(1);
   endtask

   initial begin
      // 1: reset holds everything low even with both lines high.
      SysReset = 1'b0;
      ExtIrq   = 2'b11;
      IntMask  = 2'b00;
      IntAck   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_irq", {7'd0, IRQ_Int}, 8'd0);
         chk("rst_pend", {6'd0, Pending}, 8'd0);
         chk("rst_ackerr", {7'd0, AckErr}, 8'd0);
      end
      chk("rst_iid", {7'd0, IID_Sync}, 8'd0);
      doReset();

      // 2: single line, latency and ack.
      ExtIrq = 2'b01;
      tick(2);
      chk("t2_pend_e2", {6'd0, Pending}, 8'd0);
      tick(1);
      chk("t2_pend_e3", {6'd0, Pending}, 8'd1);
      chk("t2_irq_e3", {7'd0, IRQ_Int}, 8'd0);
      tick(1);
      chk("t2_irq_e4", {7'd0, IRQ_Int}, 8'd1);
      chk("t2_iid_e4", {7'd0, IID_Sync}, 8'd0);
      IntAck = 1'b1;
      ExtIrq = 2'b00;
      tick(1);
      IntAck = 1'b0;
      chk("t2_irq_ack", {7'd0, IRQ_Int}, 8'd0);
      chk("t2_ackerr", {7'd0, AckErr}, 8'd0);
      chk("t2_pend_ack", {6'd0, Pending}, EDGE ? 8'd0 : 8'd1);
      tick(3);
      chk("t2_irq_e8", {7'd0, IRQ_Int}, 8'd0);
      chk("t2_pend_e8", {6'd0, Pending}, 8'd0);
      doReset();

      // 3: both lines together, ID1 first, ID0 after the blanking window.
      ExtIrq = 2'b11;
      tick(4);
      chk("t3_irq_e4", {7'd0, IRQ_Int}, 8'd1);
      chk("t3_iid_e4", {7'd0, IID_Sync}, 8'd1);
      IntAck = 1'b1;
      ExtIrq = 2'b01;
      tick(1);
      IntAck = 1'b0;
      chk("t3_irq_e5", {7'd0, IRQ_Int}, 8'd0);
      tick(1);
      chk("t3_irq_e6", {7'd0, IRQ_Int}, 8'd0);
      tick(1);
      chk("t3_irq_e7", {7'd0, IRQ_Int}, 8'd0);
      chk("t3_pend_e7", {6'd0, Pending}, 8'd1);
      tick(1);
      chk("t3_irq_e8", {7'd0, IRQ_Int}, 8'd1);
      chk("t3_iid_e8", {7'd0, IID_Sync}, 8'd0);
      IntAck = 1'b1;
      ExtIrq = 2'b00;
      tick(1);
      IntAck = 1'b0;
      tick(3);
      chk("t3_irq_e12", {7'd0, IRQ_Int}, 8'd0);
      chk("t3_pend_e12", {6'd0, Pending}, 8'd0);
      doReset();

      // 4: preemption by ID1, then masking ID1 returns to ID0.
      ExtIrq = 2'b01;
      tick(4);
      chk("t4_iid_e4", {7'd0, IID_Sync}, 8'd0);
      ExtIrq = 2'b11;
      tick(3);
      chk("t4_irq_e7", {7'd0, IRQ_Int}, 8'd1);
      chk("t4_iid_e7", {7'd0, IID_Sync}, 8'd0);
      tick(1);
      chk("t4_irq_e8", {7'd0, IRQ_Int}, 8'd1);
      chk("t4_iid_e8", {7'd0, IID_Sync}, 8'd1);
      IntMask = 2'b10;
      tick(1);
      chk("t4_irq_e9", {7'd0, IRQ_Int}, 8'd1);
      chk("t4_iid_e9", {7'd0, IID_Sync}, 8'd0);
      IntAck = 1'b1;
      tick(1);
      IntAck = 1'b0;
      chk("t4_irq_ack", {7'd0, IRQ_Int}, 8'd0);
      doReset();

      // 5: stray ack in IDLE, masked pending, then async reset during REQ.
      IntMask = 2'b11;
      ExtIrq  = 2'b01;
      tick(4);
      chk("t5_irq_mask", {7'd0, IRQ_Int}, 8'd0);
      chk("t5_pend_mask", {6'd0, Pending}, 8'd1);
      IntAck = 1'b1;
      tick(1);
      IntAck = 1'b0;
      chk("t5_ackerr", {7'd0, AckErr}, 8'd1);
      chk("t5_pend_err", {6'd0, Pending}, 8'd1);
      chk("t5_irq_err", {7'd0, IRQ_Int}, 8'd0);
      tick(1);
      chk("t5_ackerr_clr", {7'd0, AckErr}, 8'd0);
      IntMask = 2'b00;
      tick(1);
      chk("t5_irq_unmask", {7'd0, IRQ_Int}, 8'd1);
      SysReset = 1'b0;
      #1;
      chk("t5_irq_async", {7'd0, IRQ_Int}, 8'd0);
      chk("t5_pend_async", {6'd0, Pending}, 8'd0);
      doReset();

      // 6: line held high through an ack.
      ExtIrq = 2'b01;
      tick(4);
      chk("t6_irq_e4", {7'd0, IRQ_Int}, 8'd1);
      IntAck = 1'b1;
      tick(1);
      IntAck = 1'b0;
      chk("t6_irq_ack", {7'd0, IRQ_Int}, 8'd0);
      tick(2);
      chk("t6_irq_e7", {7'd0, IRQ_Int}, 8'd0);
      tick(1);
      chk("t6_irq_e8", {7'd0, IRQ_Int}, EDGE ? 8'd0 : 8'd1);
      chk("t6_iid_e8", {7'd0, IID_Sync}, 8'd0);
`ifdef INT_EDGE_TRIG_EN
      tick(50);
      chk("t6_irq_held", {7'd0, IRQ_Int}, 8'd0);
      chk("t6_pend_held", {6'd0, Pending}, 8'd0);
      doReset();
      // New rising edge lands on the same edge as the ack of ID0.
      ExtIrq = 2'b01;
      tick(4);
      chk("t6b_irq_e4", {7'd0, IRQ_Int}, 8'd1);
      ExtIrq = 2'b00;
      tick(1);
      ExtIrq = 2'b01;
      tick(2);
      chk("t6b_irq_e7", {7'd0, IRQ_Int}, 8'd1);
      IntAck = 1'b1;
      tick(1);
      IntAck = 1'b0;
      chk("t6b_irq_e8", {7'd0, IRQ_Int}, 8'd0);
      chk("t6b_pend_e8", {6'd0, Pending}, 8'd1);
      tick(3);
      chk("t6b_irq_e11", {7'd0, IRQ_Int}, 8'd1);
      chk("t6b_iid_e11", {7'd0, IID_Sync}, 8'd0);
`endif

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
